// File: rtl/bus_drive_sequencer.sv
// bus_drive_sequencer: serialises a request mask into one-hot bus drive strobes, one per acked transaction.
module bus_drive_sequencer #(
    parameter int N           = 32,
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] req,
    input  logic         load,
    input  logic         ack,
    output logic [N-1:0] r_out,
    output logic         valid,
    output logic         busy,
    output logic         done
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

    state_t        state_q;
    logic [N-1:0]  pending_q, r_out_q;
    logic [PW-1:0] ptr_q;
    logic          valid_q, busy_q, done_q;
    logic [N-1:0]  rem_d;
    logic [PW-1:0] g_d, nptr_d;

    // First set bit of m, searching upward from p with wrap (or from 0 in fixed priority).
    function automatic logic [N-1:0] sel(input logic [N-1:0] m, input logic [PW-1:0] p);
        logic [N-1:0] r;
        logic         hit;
        int           idx;
        r   = '0;
        hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            idx = ROUND_ROBIN ? (int'(p) + i) % N : i;
            if (!hit && m[idx]) begin
                r[idx] = 1'b1;
                hit    = 1'b1;
            end
        end
        return r;
    endfunction

    function automatic logic [PW-1:0] idx_of(input logic [N-1:0] v);
        logic [PW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            if (v[i]) r = r | PW'(i);
        return r;
    endfunction

    always_comb begin
        g_d    = idx_of(r_out_q);
        rem_d  = pending_q & ~r_out_q;
        nptr_d = (g_d == PW'(N - 1)) ? '0 : g_d + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= '0;
            r_out_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (load) begin
                    busy_q <= 1'b1;
                    if (|req) begin
                        pending_q <= req;
                        r_out_q   <= sel(req, ptr_q);
                        valid_q   <= 1'b1;
                        state_q   <= GRANT;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                GRANT: if (ack) begin
                    pending_q <= rem_d;
                    ptr_q     <= nptr_d;
                    if (|rem_d) begin
                        r_out_q <= sel(rem_d, nptr_d);
                    end else begin
                        r_out_q <= '0;
                        valid_q <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign r_out = r_out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
endmodule

// File: tb/tb_bus_drive_sequencer.sv
// tb_bus_drive_sequencer: round-robin and fixed-priority instances checked against a mask/queue model every cycle.
module tb_bus_drive_sequencer;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [31:0] req = '0;
    logic        load = 1'b0;
    logic        ack = 1'b0;
    logic [31:0] ro [2];
    logic        vl [2];
    logic        bs [2];
    logic        dn [2];
    int          checks = 0;
    int          failures = 0;
    bit          started = 1'b0;

    // Model: phase 0 idle, 1 granting, 2 done; g is current grant index or -1.
    int          m_phase [2];
    logic [31:0] m_pend [2];
    int          m_ptr [2];
    int          m_g [2];

    always #5 clk = ~clk;

    bus_drive_sequencer #(.N(32), .ROUND_ROBIN(1'b1)) u_rr (
        .clk(clk), .clr(clr), .req(req), .load(load), .ack(ack),
        .r_out(ro[0]), .valid(vl[0]), .busy(bs[0]), .done(dn[0])
    );
    bus_drive_sequencer #(.N(32), .ROUND_ROBIN(1'b0)) u_fx (
        .clk(clk), .clr(clr), .req(req), .load(load), .ack(ack),
        .r_out(ro[1]), .valid(vl[1]), .busy(bs[1]), .done(dn[1])
    );

    function automatic int find(input logic [31:0] m, input int start, input bit rr);
        for (int i = 0; i < 32; i++) begin
            int idx;
            idx = rr ? (start + i) % 32 : i;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (clr) begin
                m_phase[k] = 0; m_pend[k] = '0; m_ptr[k] = 0; m_g[k] = -1;
            end else if (m_phase[k] == 0) begin
                if (load && req != 0) begin
                    m_pend[k] = req;
                    m_g[k] = find(req, m_ptr[k], k == 0);
                    m_phase[k] = 1;
                end else if (load) begin
                    m_phase[k] = 2;
                end
            end else if (m_phase[k] == 1) begin
                if (ack) begin
                    m_pend[k][m_g[k]] = 1'b0;
                    m_ptr[k] = (m_g[k] + 1) % 32;
                    m_g[k] = find(m_pend[k], m_ptr[k], k == 0);
                    if (m_g[k] < 0) m_phase[k] = 2;
                end
            end else begin
                m_phase[k] = 0;
            end
        end
    end

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s inst%0d t=%0t got=%h exp=%h", name, inst, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            for (int k = 0; k < 2; k++) begin
                chk("model_r_out", k, ro[k], m_g[k] >= 0 ? (32'h1 << m_g[k]) : 32'h0);
                chk("model_valid", k, {31'h0, vl[k]}, {31'h0, m_g[k] >= 0});
                chk("model_busy", k, {31'h0, bs[k]}, {31'h0, m_phase[k] != 0});
                chk("model_done", k, {31'h0, dn[k]}, {31'h0, m_phase[k] == 2});
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        tick(); tick();
        clr = 1'b0;
        started = 1'b1;
        chk("reset_r_out", 0, ro[0], 32'h0);
        chk("reset_busy", 0, {31'h0, bs[0]}, 32'h0);
        // empty batch
        load = 1'b1; req = 32'h0; tick();
        chk("empty_done", 0, {31'h0, dn[0]}, 32'h1);
        chk("empty_busy", 0, {31'h0, bs[0]}, 32'h1);
        chk("empty_valid", 0, {31'h0, vl[0]}, 32'h0);
        load = 1'b0; tick();
        chk("empty_idle", 0, {31'h0, bs[0]}, 32'h0);
        // three-source batch, ack held
        load = 1'b1; req = 32'h8000_0011; ack = 1'b1; tick();
        chk("b3_g0", 0, ro[0], 32'h0000_0001);
        load = 1'b0; tick();
        chk("b3_g1", 0, ro[0], 32'h0000_0010);
        tick();
        chk("b3_g2", 0, ro[0], 32'h8000_0000);
        tick();
        chk("b3_end_r", 0, ro[0], 32'h0);
        chk("b3_end_done", 0, {31'h0, dn[0]}, 32'h1);
        tick();
        // wrap from ptr 0, then from ptr 3
        load = 1'b1; req = 32'h6; tick();
        chk("w0_g0", 0, ro[0], 32'h2);
        load = 1'b0; tick();
        chk("w0_g1", 0, ro[0], 32'h4);
        tick(); tick();
        load = 1'b1; req = 32'h6; tick();
        chk("w3_g0", 0, ro[0], 32'h2);
        load = 1'b0; tick();
        chk("w3_g1", 0, ro[0], 32'h4);
        tick(); tick();
        // ptr=3 separates the orderings
        load = 1'b1; req = 32'h11; tick();
        chk("rr_p3", 0, ro[0], 32'h10);
        chk("fx_p3", 1, ro[1], 32'h1);
        load = 1'b0; tick();
        chk("rr_p3_g1", 0, ro[0], 32'h1);
        tick(); tick();
        // stall with ack low, mid-stall load/req change ignored
        load = 1'b1; req = 32'h300; ack = 1'b0; tick();
        load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin load = 1'b1; req = 32'hFFFF_FFFF; end
            else load = 1'b0;
            tick();
            chk("stall_hold", 0, ro[0], 32'h100);
            chk("stall_valid", 0, {31'h0, vl[0]}, 32'h1);
        end
        load = 1'b0; ack = 1'b1; tick();
        chk("stall_next", 0, ro[0], 32'h200);
        tick();
        ack = 1'b0; tick();
        // reset mid-batch
        load = 1'b1; req = 32'hF; ack = 1'b1; tick();
        load = 1'b0; tick();
        clr = 1'b1; ack = 1'b0; tick();
        chk("clr_r_out", 0, ro[0], 32'h0);
        chk("clr_busy", 0, {31'h0, bs[0]}, 32'h0);
        chk("clr_done", 0, {31'h0, dn[0]}, 32'h0);
        clr = 1'b0; load = 1'b1; req = 32'h8; tick();
        chk("clr_reload", 0, ro[0], 32'h8);
        load = 1'b0; ack = 1'b1; tick(); tick();
        // back-to-back batches with load held through GRANT and DONE
        load = 1'b1; req = 32'h5; tick();
        chk("fx_a0", 1, ro[1], 32'h1);
        tick();
        chk("fx_a1", 1, ro[1], 32'h4);
        tick();
        chk("fx_a_done", 1, {31'h0, dn[1]}, 32'h1);
        tick();
        chk("fx_a_idle", 1, {31'h0, bs[1]}, 32'h0);
        tick();
        chk("fx_b0", 1, ro[1], 32'h1);
        load = 1'b0; tick();
        chk("fx_b1", 1, ro[1], 32'h4);
        tick(); tick(); tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
